// File: rtl/tnn_feature_packer.sv
// Quantizes raw feature beats to 2 bits and packs N_FEAT of them into one double-buffered output vector.
// Optional saturating vector/drop counters are enabled with `define TNN_PACK_STATS_EN.
module tnn_feature_packer #(
  parameter int N_FEAT = 5,
  parameter int RAW_W = 8,
  parameter logic [RAW_W-1:0] TH0 = 8'd64,
  parameter logic [RAW_W-1:0] TH1 = 8'd128,
  parameter logic [RAW_W-1:0] TH2 = 8'd192
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RAW_W-1:0]      in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*N_FEAT-1:0]   out_vec,
  output logic                  err
`ifdef TNN_PACK_STATS_EN
  ,
  output logic [15:0]           vec_cnt,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int VEC_W = 2 * N_FEAT;
  localparam int IDX_W = $clog2(N_FEAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FULL    = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [VEC_W-1:0]   out_vec_reg;
  logic               out_valid_reg;
  logic               in_ready_reg;
  logic               err_reg;
  logic [1:0]         q;
  logic [VEC_W-1:0]   collect_vec;
  logic [VEC_W-1:0]   complete_vec;

  logic accept, out_hs, collecting, at_end, complete, short_err, long_err, out_free;

  // Equality selects the higher bin.
  always_comb begin
    q = 2'd0;
    if (in_data >= TH2)
      q = 2'd3;
    else if (in_data >= TH1)
      q = 2'd2;
    else if (in_data >= TH0)
      q = 2'd1;
  end

  assign accept     = in_valid & in_ready_reg;
  assign out_hs     = out_valid_reg & out_ready;
  assign collecting = accept && (state_reg == COLLECT);
  assign at_end     = (idx_reg == LAST_IDX);
  assign complete   = collecting && at_end && in_last;
  assign short_err  = collecting && in_last && !at_end;
  assign long_err   = collecting && at_end && !in_last;
  assign out_free   = !out_valid_reg || out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N_FEAT; gi++) begin : g_lane
      logic [1:0] lane_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          lane_reg <= 2'd0;
        else if (collecting && (idx_reg == IDX_W'(gi)))
          lane_reg <= q;
      end
      assign collect_vec[2*gi +: 2] = lane_reg;
    end
  endgenerate

  // The final beat bypasses the collect register so a free output loads with 1-cycle latency.
  assign complete_vec = {q, collect_vec[VEC_W-3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= COLLECT;
      idx_reg       <= '0;
      out_vec_reg   <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= short_err | long_err;
      if (out_hs)
        out_valid_reg <= 1'b0;
      case (state_reg)
        COLLECT: begin
          if (complete) begin
            if (out_free) begin
              out_vec_reg   <= complete_vec;
              out_valid_reg <= 1'b1;
              idx_reg       <= '0;
            end else begin
              state_reg    <= FULL;
              in_ready_reg <= 1'b0;
            end
          end else if (short_err) begin
            idx_reg <= '0;
          end else if (long_err) begin
            idx_reg   <= '0;
            state_reg <= DRAIN;
          end else if (collecting) begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        FULL: begin
          if (out_hs) begin
            out_vec_reg   <= collect_vec;
            out_valid_reg <= 1'b1;
            idx_reg       <= '0;
            state_reg     <= COLLECT;
            in_ready_reg  <= 1'b1;
          end
        end
        DRAIN: begin
          if (accept && in_last)
            state_reg <= COLLECT;
        end
        default: begin
          state_reg    <= COLLECT;
          idx_reg      <= '0;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_vec   = out_vec_reg;
  assign err       = err_reg;

`ifdef TNN_PACK_STATS_EN
  logic [15:0] vec_cnt_reg;
  logic [15:0] drop_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt_reg  <= 16'd0;
      drop_cnt_reg <= 16'd0;
    end else begin
      if (out_hs && (vec_cnt_reg != 16'hFFFF))
        vec_cnt_reg <= vec_cnt_reg + 16'd1;
      if ((short_err || long_err) && (drop_cnt_reg != 16'hFFFF))
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign vec_cnt  = vec_cnt_reg;
  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_tnn_feature_packer.sv
// Directed bench for tnn_feature_packer: scoreboard of expected vectors popped on each output handshake.
module tb_tnn_feature_packer;
  localparam int N  = 5;
  localparam int VW = 2 * N;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_vec;
  logic          err;
`ifdef TNN_PACK_STATS_EN
  logic [15:0]   vec_cnt;
  logic [15:0]   drop_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int hs_cnt    = 0;
  int err_cnt   = 0;
  int stall_cnt = 0;
  logic [VW-1:0] sb[$];
  logic [7:0]    beat_buf [8];
  logic          hold_prev = 1'b0;
  logic [VW-1:0] vec_prev  = '0;

  tnn_feature_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .err       (err)
`ifdef TNN_PACK_STATS_EN
    ,
    .vec_cnt   (vec_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] quant(input logic [7:0] x);
    if (x >= 8'd192) return 2'd3;
    if (x >= 8'd128) return 2'd2;
    if (x >= 8'd64)  return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [VW-1:0] pack_exp();
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[2*i +: 2] = quant(beat_buf[i]);
    return r;
  endfunction

  // Holds the beat until in_ready is seen, then returns 1 ns after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic l);
    int waits;
    waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready) begin
      waits++;
      stall_cnt++;
      if (waits > 200) begin
        check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input int last_at);
    for (int i = 0; i < n; i++) send_beat(beat_buf[i], (i == last_at));
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard pops, hold stability and err pulse counting.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_vec", 32'(out_vec), 32'(vec_prev));
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        check("sb_pending", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          logic [VW-1:0] exp_v;
          exp_v = sb.pop_front();
          $display("vec %0d: out_vec=%h expected=%h", hs_cnt, out_vec, exp_v);
          check("sb_vec", 32'(out_vec), 32'(exp_v));
        end
      end
      if (err) err_cnt++;
      hold_prev = out_valid && !out_ready;
      vec_prev  = out_vec;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_before;
    logic [VW-1:0] exp_v;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_vec", 32'(out_vec), 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Quantizer boundaries, 1-cycle latency, single-cycle out_valid.
    out_ready = 1'b1;
    beat_buf[0] = 8'd63; beat_buf[1] = 8'd64; beat_buf[2] = 8'd127;
    beat_buf[3] = 8'd128; beat_buf[4] = 8'd192;
    exp_v = 10'b11_10_01_01_00;
    sb.push_back(exp_v);
    send_frame(N, N - 1);
    check("q_latency_valid", {31'd0, out_valid}, 32'd1);
    check("q_vec", 32'(out_vec), 32'(exp_v));
    idle(1);
    check("q_valid_drop", {31'd0, out_valid}, 32'd0);

    // Backpressure: second vector parks in the collect register.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) beat_buf[i] = 8'd255;
    sb.push_back(pack_exp());
    send_frame(N, N - 1);
    for (int i = 0; i < N; i++) beat_buf[i] = 8'd0;
    sb.push_back(pack_exp());
    send_frame(N, N - 1);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_out_vec_held", 32'(out_vec), 32'h3FF);
    idle(3);
    check("bp_in_ready_still_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    idle(1);
    check("bp_second_valid", {31'd0, out_valid}, 32'd1);
    check("bp_second_vec", 32'(out_vec), 32'h000);
    check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    idle(1);
    check("bp_valid_drop", {31'd0, out_valid}, 32'd0);

    // Short frame.
    beat_buf[0] = 8'd10; beat_buf[1] = 8'd200; beat_buf[2] = 8'd100;
    send_frame(3, 2);
    check("short_err_pulse", {31'd0, err}, 32'd1);
    idle(1);
    check("short_err_clear", {31'd0, err}, 32'd0);
    check("short_no_valid", {31'd0, out_valid}, 32'd0);
    beat_buf[0] = 8'd191; beat_buf[1] = 8'd0; beat_buf[2] = 8'd255;
    beat_buf[3] = 8'd65; beat_buf[4] = 8'd130;
    sb.push_back(pack_exp());
    send_frame(N, N - 1);
    idle(2);

    // Long frame: err after the 5th beat, 6th and 7th drained.
    for (int i = 0; i < 7; i++) beat_buf[i] = 8'(40 * i);
    for (int i = 0; i < 7; i++) begin
      send_beat(beat_buf[i], (i == 6));
      if (i == 4) check("long_err_pulse", {31'd0, err}, 32'd1);
      if (i >= 5) check("long_err_single", {31'd0, err}, 32'd0);
    end
    idle(1);
    check("long_no_valid", {31'd0, out_valid}, 32'd0);
    beat_buf[0] = 8'd64; beat_buf[1] = 8'd128; beat_buf[2] = 8'd192;
    beat_buf[3] = 8'd63; beat_buf[4] = 8'd127;
    sb.push_back(pack_exp());
    send_frame(N, N - 1);
    idle(2);
    check("err_count", 32'(err_cnt), 32'd2);

    // Streaming: 20 back-to-back random vectors.
    stall_cnt = 0;
    hs_before = hs_cnt;
    for (int v = 0; v < 20; v++) begin
      for (int i = 0; i < N; i++) beat_buf[i] = 8'($urandom_range(0, 255));
      sb.push_back(pack_exp());
      send_frame(N, N - 1);
    end
    idle(1);
    check("stream_no_stall", 32'(stall_cnt), 32'd0);
    check("stream_handshakes", 32'(hs_cnt - hs_before), 32'd20);
    idle(1);
`ifdef TNN_PACK_STATS_EN
    check("stats_vec_cnt", 32'(vec_cnt), 32'd25);
    check("stats_drop_cnt", 32'(drop_cnt), 32'd2);
`endif

    // Reset mid-vector.
    beat_buf[0] = 8'd250; beat_buf[1] = 8'd250;
    send_frame(2, -1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Held vector lost on reset; fresh frame after the mid-vector reset must be aligned.
    out_ready = 1'b0;
    beat_buf[0] = 8'd1; beat_buf[1] = 8'd70; beat_buf[2] = 8'd140;
    beat_buf[3] = 8'd210; beat_buf[4] = 8'd128;
    send_frame(N, N - 1);
    check("rst_hold_vec", 32'(out_vec), 32'(pack_exp()));
    idle(2);
    check("rst_hold_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", {31'd0, out_valid}, 32'd0);
    check("rst_async_vec", 32'(out_vec), 32'd0);
`ifdef TNN_PACK_STATS_EN
    check("stats_vec_rst", 32'(vec_cnt), 32'd0);
    check("stats_drop_rst", 32'(drop_cnt), 32'd0);
`endif
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    out_ready = 1'b1;
    beat_buf[0] = 8'd200; beat_buf[1] = 8'd150; beat_buf[2] = 8'd90;
    beat_buf[3] = 8'd30; beat_buf[4] = 8'd64;
    sb.push_back(pack_exp());
    send_frame(N, N - 1);
    idle(2);
`ifdef TNN_PACK_STATS_EN
    check("stats_vec_after", 32'(vec_cnt), 32'd1);
`endif
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("total_handshakes", 32'(hs_cnt), 32'd26);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tnn_feature_packer.md
Name: tnn_feature_packer

Overview:
- Producer-side front end for the 2-bit approximate TNN classifier cores (five 2-bit feature inputs, 1-bit decision).
- Accepts raw unsigned feature samples one per beat on a valid/ready stream.
- Quantizes each sample to 2 bits against three ascending thresholds.
- Packs N_FEAT quantized features into one vector and presents it on a valid/ready output, double-buffered so the next vector can be collected while the current one stalls.

Parameters:
- N_FEAT, 5, features per vector (2..16).
- RAW_W, 8, raw feature width.
- TH0, 8'd64, lower threshold.
- TH1, 8'd128, middle threshold.
- TH2, 8'd192, upper threshold. Requires TH0 <= TH1 <= TH2.

Ports:
- clk  in  1  clock, all flops rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  raw feature beat valid.
- in_ready  out  1  packer can accept beat.
- in_data  in  RAW_W  raw unsigned feature.
- in_last  in  1  beat is final feature of a vector.
- out_valid  out  1  packed vector valid.
- out_ready  in  1  classifier side accepts vector.
- out_vec  out  2*N_FEAT  packed vector; feature i at bits [2i+1:2i]. Feature 0 maps to classifier input_a, 1 to input_b, and so on.
- err  out  1  one-cycle pulse on framing error.

Behaviour:
- Reset (async assert, sync release): in_ready=1, out_valid=0, out_vec=0, err=0, idx=0, state=COLLECT, collect register cleared.
- Quantize: q = 3 if x>=TH2; else 2 if x>=TH1; else 1 if x>=TH0; else 0. Comparison is unsigned, and equality selects the higher bin.
- A beat is accepted when in_valid & in_ready. It is written to collect[idx] and idx increments.
- States:
  - COLLECT: in_ready=1.
  - FULL: complete vector waiting in the collect register; in_ready=0.
  - DRAIN: discarding beats until in_last; in_ready=1.
- Completion: beat accepted with idx==N_FEAT-1 and in_last=1.
  - If out_valid==0, or out_valid & out_ready in the same cycle, the completed vector (including this beat) loads out_vec. out_valid=1 on the next cycle, so latency from the last beat is 1 cycle. idx returns to 0; stay in COLLECT.
  - Otherwise go to FULL.
- FULL: when out_valid & out_ready, move collect to out_vec, keep out_valid=1, idx=0, return to COLLECT. in_ready returns to 1 on the following cycle.
- out_vec and out_valid are stable while out_valid & !out_ready.
- out_valid falls only on handshake with no replacement vector pending.
- Short frame: in_last=1 with idx<N_FEAT-1. Drop the partial vector, pulse err, idx=0, stay in COLLECT.
- Long frame: idx==N_FEAT-1 with in_last=0. Drop the vector, pulse err, idx=0, go to DRAIN.
- DRAIN: accepts and discards beats. On an accepted beat with in_last=1, go to COLLECT; no second err pulse.
- Error beats never touch out_vec or out_valid, and a pending output handshake still completes normally in the same cycle.
- in_valid low: no state change except output handshake.
- Reset mid-vector: partial vector and held output lost, out_valid=0 immediately on rst_n low.
- Throughput: one beat per cycle sustained when out_ready=1. One vector per N_FEAT cycles.

Optional Feature:
- Macro TNN_PACK_STATS_EN.
- When defined, adds two outputs:
  - vec_cnt [15:0]: increments on each output handshake.
  - drop_cnt [15:0]: increments on each err pulse.
- Both counters saturate at 16'hFFFF and reset to 0.
- When not defined, those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Quantizer boundaries: send 5 beats 63, 64, 127, 128, 192 with last on the 5th, out_ready=1. Expect out_vec=10'b11_10_01_01_00 one cycle after the 5th beat, out_valid high for 1 cycle.
- Backpressure: out_ready=0, send two full vectors (all 255, then all 0). Expect out_vec=10'h3FF held, in_ready=0 after the 10th beat. Raise out_ready, then expect 10'h000 next, with no beat lost or duplicated.
- Short frame: in_last on the 3rd beat. Expect err pulse one cycle, no out_valid; the next correct 5-beat vector emits normally.
- Long frame: 7 beats, in_last on the 7th. Expect err on the 5th beat, beats 6–7 discarded; the following vector is correct.
- Streaming: 20 back-to-back vectors with out_ready=1. Expect in_ready constantly 1, 20 handshakes, each vector matching the reference quantizer.
- Reset: assert rst_n low mid-vector and while out_valid is held. Expect out_valid=0 asynchronously; a fresh vector after release emits correctly. With TNN_PACK_STATS_EN defined, expect vec_cnt and drop_cnt to match the counts above and reset to 0.
